// File: rtl/aes_stream_wrap.sv
// Stream front end for an external 128-bit AES core: gathers block and key beats,
// runs the core through a start/done handshake with timeout, and streams the result back.
module aes_stream_wrap #(
  parameter int unsigned IN_W         = 8,
  parameter int unsigned OUT_W        = 16,
  parameter int unsigned CORE_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic [IN_W-1:0]   in_key,
  input  logic              mode_in,
  input  logic              key_keep,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic              core_start,
  output logic              core_mode,
  output logic [127:0]      core_data,
  output logic [127:0]      core_key,
  input  logic              core_done,
  input  logic [127:0]      core_result,
  output logic              busy,
  output logic              err
);

  localparam int unsigned InBeats    = 128 / IN_W;
  localparam int unsigned OutBeats   = 128 / OUT_W;
  localparam logic [8:0]  TimeoutLim = 9'(CORE_TIMEOUT);

  typedef enum logic [1:0] {StLoad, StStart, StWait, StUnload} state_e;

  state_e       state_q;
  logic [4:0]   in_cnt_q;
  logic [4:0]   out_cnt_q;
  logic [7:0]   to_cnt_q;
  logic [127:0] data_q;
  logic [127:0] key_q;
  logic [127:0] result_q;
  logic         keep_q;

  logic in_hs;
  logic key_hold;
  logic timeout;

  assign in_hs     = in_valid & in_ready;
  // The first beat governs the key path for the whole block, including itself.
  assign key_hold  = (in_cnt_q == 5'd0) ? key_keep : keep_q;
  // err is registered, so the abort decision is taken one cycle before it shows.
  assign timeout   = ({1'b0, to_cnt_q} + 9'd2) >= TimeoutLim;
  assign out_data  = result_q[127 -: OUT_W];
  assign core_data = data_q;
  assign core_key  = key_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StLoad;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      to_cnt_q   <= '0;
      data_q     <= '0;
      key_q      <= '0;
      result_q   <= '0;
      keep_q     <= 1'b0;
      core_mode  <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      core_start <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      core_start <= 1'b0;
      err        <= 1'b0;
      case (state_q)
        StLoad: begin
          in_ready <= 1'b1;
          if (in_hs) begin
            busy   <= 1'b1;
            data_q <= {data_q[127-IN_W:0], in_data};
            if (!key_hold) begin
              key_q <= {key_q[127-IN_W:0], in_key};
            end
            if (in_cnt_q == 5'd0) begin
              core_mode <= mode_in;
              keep_q    <= key_keep;
            end
            if (in_cnt_q == 5'(InBeats - 1)) begin
              in_cnt_q   <= '0;
              in_ready   <= 1'b0;
              core_start <= 1'b1;
              state_q    <= StStart;
            end else begin
              in_cnt_q <= in_cnt_q + 5'd1;
            end
          end
        end
        StStart: begin
          to_cnt_q <= '0;
          state_q  <= StWait;
        end
        StWait: begin
          to_cnt_q <= to_cnt_q + 8'd1;
          if (core_done) begin
            result_q <= core_result;
            state_q  <= StUnload;
          end else if (timeout) begin
            err      <= 1'b1;
            busy     <= 1'b0;
            in_ready <= 1'b1;
            state_q  <= StLoad;
          end
        end
        StUnload: begin
          // One idle cycle after capture before the first beat is offered.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            result_q <= {result_q[127-OUT_W:0], {OUT_W{1'b0}}};
            if (out_cnt_q == 5'(OutBeats - 1)) begin
              out_cnt_q <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              state_q   <= StLoad;
            end else begin
              out_cnt_q <= out_cnt_q + 5'd1;
              out_last  <= (out_cnt_q + 5'd1) == 5'(OutBeats - 1);
            end
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

endmodule
